// File: rtl/reset_hold_counter_pkg.sv
// Shared defaults for the BlackJack reset-button hold timer.
package reset_hold_counter_pkg;

    localparam int RHC_WIDTH      = 12;
    localparam int RHC_DEB_CYCLES = 1;

    localparam logic [RHC_WIDTH-1:0] CNT_MAX = {RHC_WIDTH{1'b1}};

endpackage : reset_hold_counter_pkg

// File: rtl/reset_debouncer.sv
// Synchronizes and debounces the active-low reset button; emits press/release pulses.
module reset_debouncer
    import reset_hold_counter_pkg::*;
#(
    parameter int DEB_CYCLES = RHC_DEB_CYCLES
) (
    input  logic clk_2K,
    input  logic i_Reset,
    input  logic i_Button,
    output logic o_ButtonDeb,
    output logic o_ButtonDown,
    output logic o_ButtonUp
);

    localparam logic [7:0] DEB_LIMIT = 8'(DEB_CYCLES - 1);

    logic       sync_q;
    logic       deb_q;
    logic       deb_d;
    logic       deb_dly_q;
    logic [7:0] stab_q;
    logic [7:0] stab_d;

    // A level change is accepted only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d  = deb_q;
        stab_d = stab_q;
        if (sync_q != deb_q) begin
            if (stab_q == DEB_LIMIT) begin
                deb_d  = sync_q;
                stab_d = 8'd0;
            end else begin
                stab_d = stab_q + 8'd1;
            end
        end else begin
            stab_d = 8'd0;
        end
    end

    // Released (1) is the safe idle level for every button-path flop.
    always_ff @(posedge clk_2K or negedge i_Reset) begin
        if (!i_Reset) begin
            sync_q    <= 1'b1;
            deb_q     <= 1'b1;
            deb_dly_q <= 1'b1;
            stab_q    <= 8'd0;
        end else begin
            sync_q    <= i_Button;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            stab_q    <= stab_d;
        end
    end

    assign o_ButtonDeb  = deb_q;
    assign o_ButtonDown = deb_dly_q & ~deb_q;
    assign o_ButtonUp   = ~deb_dly_q & deb_q;

endmodule : reset_debouncer

// File: rtl/reset_hold_counter.sv
// Saturating hold/general timer driven by the debounced player reset button.
module reset_hold_counter
    import reset_hold_counter_pkg::*;
#(
    parameter int WIDTH      = RHC_WIDTH,
    parameter int DEB_CYCLES = RHC_DEB_CYCLES
) (
    input  logic             clk_2K,
    input  logic             i_Reset,
    input  logic             i_Button,
    input  logic             i_ActCounter,
    input  logic             i_RstCounter,
    output logic [WIDTH-1:0] o_Count,
    output logic             o_TwoSec,
    output logic             o_RstOK,
    output logic             o_ButtonDeb,
    output logic             o_ButtonDown,
    output logic             o_ButtonUp
);

    localparam logic [WIDTH-1:0] CNT_FULL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             btn_deb_s;
    logic             btn_down_s;
    logic             btn_up_s;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    reset_debouncer #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debouncer (
        .clk_2K       (clk_2K),
        .i_Reset      (i_Reset),
        .i_Button     (i_Button),
        .o_ButtonDeb  (btn_deb_s),
        .o_ButtonDown (btn_down_s),
        .o_ButtonUp   (btn_up_s)
    );

    // A fresh press restarts the hold measurement ahead of every other request.
    always_comb begin
        count_d = count_q;
        if (btn_down_s) begin
            count_d = CNT_ZERO;
        end else if (i_RstCounter) begin
            count_d = CNT_ZERO;
        end else if (i_ActCounter || !btn_deb_s) begin
            if (count_q == CNT_FULL) begin
                count_d = count_q;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_2K or negedge i_Reset) begin
        if (!i_Reset) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Count      = count_q;
    assign o_TwoSec     = (count_q == CNT_FULL);
    assign o_RstOK      = (count_q == CNT_ZERO);
    assign o_ButtonDeb  = btn_deb_s;
    assign o_ButtonDown = btn_down_s;
    assign o_ButtonUp   = btn_up_s;

endmodule : reset_hold_counter

// File: tb/tb_reset_hold_counter.sv
// Directed bench for reset_hold_counter: vector table plus multi-cycle hold sequences.
module tb_reset_hold_counter;
    import reset_hold_counter_pkg::*;

    logic        clk_2K;
    logic        i_Reset;
    logic        i_Button;
    logic        i_ActCounter;
    logic        i_RstCounter;
    logic [11:0] o_Count;
    logic        o_TwoSec;
    logic        o_RstOK;
    logic        o_ButtonDeb;
    logic        o_ButtonDown;
    logic        o_ButtonUp;

    int n_checks = 0;
    int n_errors = 0;

    reset_hold_counter dut (
        .clk_2K       (clk_2K),
        .i_Reset      (i_Reset),
        .i_Button     (i_Button),
        .i_ActCounter (i_ActCounter),
        .i_RstCounter (i_RstCounter),
        .o_Count      (o_Count),
        .o_TwoSec     (o_TwoSec),
        .o_RstOK      (o_RstOK),
        .o_ButtonDeb  (o_ButtonDeb),
        .o_ButtonDown (o_ButtonDown),
        .o_ButtonUp   (o_ButtonUp)
    );

    initial clk_2K = 1'b0;
    always #5 clk_2K = ~clk_2K;

    typedef struct {
        logic btn;
        logic act;
        logic rst;
        int   cnt;
        logic deb;
        logic dn;
        logic up;
    } vec_t;

    task automatic tick();
        @(posedge clk_2K);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input logic deb,
                           input logic dn, input logic up);
        chk({tag, " count"},  int'(o_Count),      cnt);
        chk({tag, " twosec"}, int'(o_TwoSec),     (cnt == 4095) ? 1 : 0);
        chk({tag, " rstok"},  int'(o_RstOK),      (cnt == 0) ? 1 : 0);
        chk({tag, " deb"},    int'(o_ButtonDeb),  int'(deb));
        chk({tag, " down"},   int'(o_ButtonDown), int'(dn));
        chk({tag, " up"},     int'(o_ButtonUp),   int'(up));
    endtask

    vec_t vecs[16];

    initial begin
        // btn act rst | count deb down up (sampled after the clock edge)
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0};

        i_Reset      = 1'b0;
        i_Button     = 1'b1;
        i_ActCounter = 1'b0;
        i_RstCounter = 1'b0;
        ticks(2);
        chk_all("in_reset", 0, 1'b1, 1'b0, 1'b0);
        i_Reset = 1'b1;
        ticks(3);
        chk_all("idle", 0, 1'b1, 1'b0, 1'b0);

        for (int v = 0; v < 16; v++) begin
            i_Button     = vecs[v].btn;
            i_ActCounter = vecs[v].act;
            i_RstCounter = vecs[v].rst;
            tick();
            chk_all($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].deb, vecs[v].dn, vecs[v].up);
        end
        i_ActCounter = 1'b0;
        i_RstCounter = 1'b0;

        // Fresh press from a clean reset: latency and N = 100 / 3999.
        i_Reset = 1'b0;
        #2;
        chk_all("async_rst", 0, 1'b1, 1'b0, 1'b0);
        tick();
        i_Reset = 1'b1;
        tick();
        i_Button = 1'b0;
        tick();
        chk_all("p1", 0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("p2", 0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("p3", 0, 1'b0, 1'b0, 1'b0);
        ticks(100);
        chk_all("hold100", 100, 1'b0, 1'b0, 1'b0);
        ticks(3899);
        chk_all("hold3999", 3999, 1'b0, 1'b0, 1'b0);

        // Release: two more counts through the debounce pipeline, then freeze.
        i_Button = 1'b1;
        tick();
        chk_all("r1", 4000, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("r2", 4001, 1'b1, 1'b0, 1'b1);
        ticks(5);
        chk_all("frozen", 4001, 1'b1, 1'b0, 1'b0);

        // Re-press reloads 0 regardless of the frozen value; 500-clock hold.
        i_Button = 1'b0;
        ticks(2);
        chk_all("re_p2", 4001, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("re_p3", 0, 1'b0, 1'b0, 1'b0);
        ticks(500);
        chk_all("hold500", 500, 1'b0, 1'b0, 1'b0);
        i_Button = 1'b1;
        ticks(2);
        chk_all("rel500", 502, 1'b1, 1'b0, 1'b1);
        ticks(5);
        chk_all("frz500", 502, 1'b1, 1'b0, 1'b0);

        // Clear at 37.
        i_RstCounter = 1'b1;
        tick();
        i_RstCounter = 1'b0;
        i_ActCounter = 1'b1;
        ticks(37);
        chk_all("cnt37", 37, 1'b1, 1'b0, 1'b0);
        i_ActCounter = 1'b0;
        i_RstCounter = 1'b1;
        tick();
        chk_all("clr37", 0, 1'b1, 1'b0, 1'b0);
        i_RstCounter = 1'b0;

        // Two-second flag and saturation.
        i_ActCounter = 1'b1;
        ticks(4095);
        chk_all("sat4095", 4095, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("sat4096", 4095, 1'b1, 1'b0, 1'b0);
        chk("cnt_max", int'(o_Count), int'(CNT_MAX));
        ticks(10);
        chk_all("sat_nowrap", 4095, 1'b1, 1'b0, 1'b0);

        // Reset mid-count clears immediately; counting needs a new enable.
        i_RstCounter = 1'b1;
        tick();
        i_RstCounter = 1'b0;
        ticks(5);
        chk_all("mid5", 5, 1'b1, 1'b0, 1'b0);
        #3;
        i_Reset = 1'b0;
        #1;
        chk_all("mid_rst", 0, 1'b1, 1'b0, 1'b0);
        i_ActCounter = 1'b0;
        tick();
        i_Reset = 1'b1;
        ticks(3);
        chk_all("post_rst", 0, 1'b1, 1'b0, 1'b0);
        i_ActCounter = 1'b1;
        tick();
        chk_all("resume", 1, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_reset_hold_counter

// File: doc/reset_hold_counter.md
Name: reset_hold_counter

Overview:
- Clocked 2 kHz timing block for the BlackJack game.
- Debounces the raw active-low player reset button and produces a clean level plus press/release pulses.
- Drives a saturating up-counter that measures how long the button is held (restarting from 0 on each press), and serves as a general timer (clear/enable, 2-second flag at full scale).

Parameters:
- WIDTH, 12, counter width; all-ones (4095 at 2 kHz, about 2 s) is the TwoSec threshold.
- DEB_CYCLES, 1, consecutive clocks the synchronized button must differ from the debounced level before that level changes; legal range 1..255.

Ports:
- clk_2K, in, 1: system clock (2 kHz); all state on rising edge.
- i_Reset, in, 1: system reset. Asynchronous, active-low.
- i_Button, in, 1: raw player reset button, active-low (pressed = 0), asynchronous to clk_2K.
- i_ActCounter, in, 1: count enable, active-high.
- i_RstCounter, in, 1: synchronous counter clear, active-high.
- o_Count, out, WIDTH: counter value.
- o_TwoSec, out, 1: high while o_Count is all-ones.
- o_RstOK, out, 1: high while o_Count == 0.
- o_ButtonDeb, out, 1: debounced button level (1 = released).
- o_ButtonDown, out, 1: one-clock pulse on debounced 1->0 (press).
- o_ButtonUp, out, 1: one-clock pulse on debounced 0->1 (release).

Behaviour:
- Async reset (i_Reset=0):
  - sync flop, debounced level and its delayed copy all go to 1;
  - stability counter goes to 0;
  - o_Count goes to 0, so o_RstOK=1, o_TwoSec=0, pulses 0.
- Debouncer:
  - One synchronizer flop s samples i_Button.
  - Stability counter increments while s != deb and clears when s == deb.
  - When it reaches DEB_CYCLES, deb <= s and the counter clears.
  - With the default, deb follows i_Button 2 clocks after the first sampling edge.
  - deb_d is deb delayed one clock. o_ButtonDown = deb_d & ~deb; o_ButtonUp = ~deb_d & deb. Both are combinational and high for exactly one clock.
- Counter, evaluated each rising edge, first matching rule wins:
  1. o_ButtonDown=1 -> count <= 0.
  2. i_RstCounter=1 -> count <= 0.
  3. i_ActCounter=1 or o_ButtonDeb=0 -> count <= count+1, saturating at 2^WIDTH-1 (no wrap).
  4. else hold.
- Button hold: the press clock loads 0, then the count increments once per clock while the button stays held. Release stops counting and keeps the value. A release pulse has no effect on the count.
- o_RstOK and o_TwoSec are combinational decodes of the count register (zero latency).
- Reset asserted mid-count clears everything immediately; counting resumes only after release of i_Reset and a new enable.

Decomposition:
- Shared package: WIDTH default (12), DEB_CYCLES default (1), constant CNT_MAX = 2^WIDTH-1.
- One sub-module: reset_debouncer (sync flop, stability counter, deb/deb_d, edge pulses).
- Counter logic is inline in reset_hold_counter.

Test Plan:
- Reset then idle: i_Reset=0 for 2 clocks, release, inputs idle -> o_Count=0, o_RstOK=1, o_TwoSec=0, o_ButtonDeb=1, no pulses.
- Press latency: i_Button 1->0 before edge p1 -> o_ButtonDeb=0 after p2; o_ButtonDown high between p2 and p3; o_Count=0 after p3; o_Count=N exactly N clocks later. Check N=100 and N=3999.
- Release: after a 500-clock hold, i_Button=1 -> one o_ButtonUp pulse; o_Count freezes at its value.
- Re-press: after the freeze, a second press -> count reloads 0 and restarts, regardless of the prior value.
- Clear/RstOK: i_RstCounter=1 for one clock with count=37 -> o_Count=0, o_RstOK=1 same cycle.
- TwoSec and saturation: from 0, i_ActCounter=1 for 4096 clocks -> o_Count=4095, o_TwoSec=1; 10 more clocks -> still 4095, no wrap.
